// File: rtl/edge_detector.sv
// Level-to-pulse edge detector: one-clock pulses on rising/falling transitions of signal_in.
// Latency 2 clocks, or SYNC_STAGES+2 when EDGE_DETECTOR_SYNC_EN adds the input synchronizer.
// No backpressure: pulses are fire-and-forget; a level narrower than one clock may be missed.
module edge_detector #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_in,
  output logic rising_out,
  output logic falling_out
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("edge_detector: SYNC_STAGES must be in 2..4");
  end

  logic sample;

`ifdef EDGE_DETECTOR_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  // Every stage resets to RESET_LEVEL so no false edge leaves the chain after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];
`else
  assign sample = signal_in;
`endif

  logic cur;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= RESET_LEVEL;
      prev <= RESET_LEVEL;
    end else begin
      cur  <= sample;
      prev <= cur;
    end
  end

  // Registered outputs: no combinational path from signal_in, and they are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rising_out  <= 1'b0;
      falling_out <= 1'b0;
    end else begin
      rising_out  <= cur & ~prev;
      falling_out <= ~cur & prev;
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: dut0 uses RESET_LEVEL=0, dut1 uses RESET_LEVEL=1.
// Inputs change and outputs are sampled on the falling clock edge (10 ns period).
module tb_edge_detector;

`ifdef EDGE_DETECTOR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic signal_in;
  logic rise0, fall0, rise1, fall1;

  int vectors     = 0;
  int miscompares = 0;

  edge_detector #(.SYNC_STAGES(2), .RESET_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
    .rising_out(rise0), .falling_out(fall0)
  );

  edge_detector #(.SYNC_STAGES(2), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
    .rising_out(rise1), .falling_out(fall1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Step n falling edges, tallying dut0 pulse samples and the index of the first one.
  task automatic watch(input int n, output int rc, output int fc,
                       output int rfirst, output int ffirst);
    rc = 0; fc = 0; rfirst = -1; ffirst = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("never_both", rise0 & fall0, 1'b0);
      if (rise0 === 1'b1) begin
        rc++;
        if (rfirst < 0) rfirst = i;
      end
      if (fall0 === 1'b1) begin
        fc++;
        if (ffirst < 0) ffirst = i;
      end
    end
  endtask

  initial begin
    int rc, fc, rf, ff;
    logic lvl;

    // Reset hold with signal_in toggling
    rst_n     = 1'b0;
    signal_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      signal_in = ~signal_in;
      chk("rst_rise0", rise0, 1'b0);
      chk("rst_fall0", fall0, 1'b0);
      chk("rst_rise1", rise1, 1'b0);
      chk("rst_fall1", fall1, 1'b0);
    end
    signal_in = 1'b0;
    @(negedge clk);  // t = 10 ns
    rst_n = 1'b1;

    // Release with input low: dut0 silent, dut1 sees 1->0 against its reset level
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("rel_rise0", rise0, 1'b0);
      chk("rel_fall0", fall0, 1'b0);
      chk("rel_rise1", rise1, 1'b0);
      chk("rel_fall1", fall1, i == LAT);
    end

    // Single rising edge at 110 ns
    signal_in = 1'b1;
    watch(10, rc, fc, rf, ff);
    chkn("rise_count", rc, 1);
    chkn("rise_latency", rf, LAT);
    chkn("rise_fall_count", fc, 0);

    // Single falling edge at 210 ns
    signal_in = 1'b0;
    watch(10, rc, fc, rf, ff);
    chkn("fall_count", fc, 1);
    chkn("fall_latency", ff, LAT);
    chkn("fall_rise_count", rc, 0);

    // Six toggles, 100 ns apart
    lvl = 1'b0;
    for (int t = 0; t < 6; t++) begin
      lvl = ~lvl;
      signal_in = lvl;
      watch(10, rc, fc, rf, ff);
      chkn(lvl ? "tog_rise_count" : "tog_fall_count", lvl ? rc : fc, 1);
      chkn(lvl ? "tog_rise_latency" : "tog_fall_latency", lvl ? rf : ff, LAT);
      chkn(lvl ? "tog_fall_quiet" : "tog_rise_quiet", lvl ? fc : rc, 0);
    end

    // Toggle every clock for four cycles
    for (int i = 1; i <= 12; i++) begin
      if (i <= 4) signal_in = (i % 2 == 1);
      @(negedge clk);
      chk("fast_rise", rise0, (i == LAT) || (i == LAT + 2));
      chk("fast_fall", fall0, (i == LAT + 1) || (i == LAT + 3));
      chk("fast_never_both", rise0 & fall0, 1'b0);
    end

    // Assert reset while a rising pulse is high: clears without a clock edge
    signal_in = 1'b1;
    for (int i = 1; i <= LAT; i++) @(negedge clk);
    chk("pre_reset_pulse", rise0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_clr_rise0", rise0, 1'b0);
    chk("async_clr_fall0", fall0, 1'b0);
    chk("async_clr_rise1", rise1, 1'b0);
    chk("async_clr_fall1", fall1, 1'b0);
    @(negedge clk);
    chk("rst_hold_rise0", rise0, 1'b0);

    // Release with input high: RESET_LEVEL=0 pulses, RESET_LEVEL=1 stays silent
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("lvl_rise0", rise0, i == LAT);
      chk("lvl_fall0", fall0, 1'b0);
      chk("lvl_rise1", rise1, 1'b0);
      chk("lvl_fall1", fall1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
